// File: rtl/prot_trig_pkg.sv
// Shared types for the protocol trigger controller: FSM state encoding and
// the bit position of each trigger source within src_trig/src_en.
`timescale 1ns/1ps
package prot_trig_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TRIG  = 2'd2,
        DONE  = 2'd3
    } trig_state_t;

    localparam int SRC_UART = 0;
    localparam int SRC_SPI  = 1;
    localparam int SRC_CH   = 2;

endpackage

// File: rtl/prot_trig_ctrl_qual.sv
// trig_qual: turns raw source triggers into a single fire request, either
// any-enabled-source (OR) or all-enabled-sources with sticky latches (AND).
`timescale 1ns/1ps
module trig_qual
    import prot_trig_pkg::*;
#(
    parameter int NUM_SRC = 3
)
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_active,
    input  logic               i_mode_and,
    input  logic [NUM_SRC-1:0] i_src_trig,
    input  logic [NUM_SRC-1:0] i_src_en,
    output logic               o_fire
);

    logic [NUM_SRC-1:0] r_latch;
    logic [NUM_SRC-1:0] w_hit;
    logic               w_or_fire;
    logic               w_and_fire;

    assign w_hit = i_src_trig & i_src_en;

    // Latches only accumulate while qualification is active; anything else wipes them.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_latch <= '0;
        end else if (!i_active) begin
            r_latch <= '0;
        end else begin
            r_latch <= r_latch | w_hit;
        end
    end

    assign w_or_fire  = |w_hit;
    assign w_and_fire = &(r_latch | w_hit | ~i_src_en);
    assign o_fire     = i_active && (|i_src_en) && (i_mode_and ? w_and_fire : w_or_fire);

endmodule

// File: rtl/prot_trig_ctrl.sv
// prot_trig_ctrl: arm/trigger/post-trigger-count FSM gating capture RAM writes.
// Optional holdoff after arming is enabled by defining PROT_TRIG_HOLDOFF_EN.
`timescale 1ns/1ps
module prot_trig_ctrl
    import prot_trig_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int CNT_W   = 9,
    parameter int HOLD_W  = 8
)
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_arm,
    input  logic [NUM_SRC-1:0] i_src_trig,
    input  logic [NUM_SRC-1:0] i_src_en,
    input  logic               i_mode_and,
    input  logic [CNT_W-1:0]   i_trig_pos,
    input  logic [HOLD_W-1:0]  i_holdoff,
    input  logic               i_smpl_en,
    input  logic               i_done_clr,
    output logic               o_armed,
    output logic               o_triggered,
    output logic               o_wr_en,
    output logic               o_done
);

    trig_state_t       r_state;
    trig_state_t       w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_cnt_hit;
    logic              w_qual_en;
    logic              w_fire;

`ifdef PROT_TRIG_HOLDOFF_EN
    logic [HOLD_W-1:0] r_hold;

    // Holdoff is loaded on the IDLE->ARMED edge and counts down in sample units.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hold <= '0;
        end else if (r_state == IDLE && i_arm) begin
            r_hold <= i_holdoff;
        end else if (r_state != ARMED) begin
            r_hold <= '0;
        end else if (i_smpl_en && r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
        end
    end

    assign w_qual_en = (r_state == ARMED) && (r_hold == '0);
`else
    logic w_unused_holdoff;
    assign w_unused_holdoff = ^i_holdoff;
    assign w_qual_en        = (r_state == ARMED);
`endif

    trig_qual #(
        .NUM_SRC (NUM_SRC)
    ) u_qual (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_active   (w_qual_en),
        .i_mode_and (i_mode_and),
        .i_src_trig (i_src_trig),
        .i_src_en   (i_src_en),
        .o_fire     (w_fire)
    );

    assign w_cnt_hit = (r_cnt == i_trig_pos);

    // Post-trigger sample count; holds once the target is reached and saturates at all-ones.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_state != TRIG) begin
            r_cnt <= '0;
        end else if (i_smpl_en && !w_cnt_hit && r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Dropping arm aborts from ARMED/TRIG; DONE only leaves on done_clr.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_arm) w_next = ARMED;
            ARMED:   if (!i_arm) w_next = IDLE; else if (w_fire) w_next = TRIG;
            TRIG:    if (!i_arm) w_next = IDLE; else if (w_cnt_hit) w_next = DONE;
            DONE:    if (i_done_clr) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_armed     = 1'b0;
        o_triggered = 1'b0;
        o_wr_en     = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            ARMED: begin
                o_armed = 1'b1;
                o_wr_en = i_smpl_en;
            end
            TRIG: begin
                o_armed     = 1'b1;
                o_triggered = 1'b1;
                o_wr_en     = i_smpl_en & ~w_cnt_hit;
            end
            DONE: begin
                o_triggered = 1'b1;
                o_done      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
